// File: rtl/doodle_physics_if.sv
// doodle_physics_if: bundles the step strobe, move/collision requests and the
// registered doodle state. The master side is the input/collision logic; the
// renderer observes the same outputs. springHit exists only when
// DOODLE_SPRING_EN is defined.
interface doodle_physics_if #(
  parameter int COORD_WIDTH = 16,
  parameter int VEL_WIDTH   = 8
);
  logic                          physicsUpdate;
  logic                          left;
  logic                          right;
  logic                          hasCollide;
`ifdef DOODLE_SPRING_EN
  logic                          springHit;
`endif
  logic        [COORD_WIDTH-1:0] doodleX;
  logic        [COORD_WIDTH-1:0] doodleY;
  logic signed [VEL_WIDTH-1:0]   velY;
  logic                          falling;
  logic                          dead;
  logic        [15:0]            jumpCount;

  modport master (
    output physicsUpdate, left, right, hasCollide,
`ifdef DOODLE_SPRING_EN
    output springHit,
`endif
    input  doodleX, doodleY, velY, falling, dead, jumpCount
  );

  modport slave (
    input  physicsUpdate, left, right, hasCollide,
`ifdef DOODLE_SPRING_EN
    input  springHit,
`endif
    output doodleX, doodleY, velY, falling, dead, jumpCount
  );
endinterface

// File: rtl/doodle_physics.sv
// doodle_physics: doodle state holder with a velocity/gravity jump arc,
// horizontal wrap-around motion, ceiling clamp, death below the bottom edge
// and a bounce counter. One physics step per physicsUpdate strobe.
// Optional feature macro: DOODLE_SPRING_EN (spring bounces load SPRING_VELOCITY).
module doodle_physics #(
  parameter int SCREEN_WIDTH    = 400,
  parameter int SCREEN_HEIGHT   = 700,
  parameter int COORD_WIDTH     = 16,
  parameter int VEL_WIDTH       = 8,
  parameter int JUMP_VELOCITY   = 8,
  parameter int GRAVITY         = 1,
  parameter int MAX_FALL_SPEED  = 8,
`ifdef DOODLE_SPRING_EN
  parameter int SPRING_VELOCITY = 16,
`endif
  parameter int H_SPEED         = 2
) (
  input logic              clk,
  input logic              reset,
  doodle_physics_if.slave  bus
);

  localparam int CW = COORD_WIDTH;
  localparam int VW = VEL_WIDTH;

  typedef enum logic [1:0] {ST_RISE, ST_FALL, ST_DEAD} state_t;

  localparam logic        [CW-1:0] C_WIDTH  = CW'(SCREEN_WIDTH);
  localparam logic        [CW-1:0] C_HSPEED = CW'(H_SPEED);
  localparam logic        [CW-1:0] C_XRST   = CW'(SCREEN_WIDTH / 2);
  localparam logic signed [CW:0]   C_YMAX   = (CW+1)'(SCREEN_HEIGHT - 1);
  localparam logic signed [CW:0]   C_YZERO  = '0;
  localparam logic signed [VW:0]   C_GRAV   = (VW+1)'(GRAVITY);
  localparam logic signed [VW:0]   C_VZERO  = '0;
  localparam logic signed [VW:0]   C_VMIN   = (VW+1)'(-MAX_FALL_SPEED);
  localparam logic signed [VW-1:0] C_JUMP   = VW'(JUMP_VELOCITY);
`ifdef DOODLE_SPRING_EN
  localparam logic signed [VW-1:0] C_SPRING = VW'(SPRING_VELOCITY);
`endif

  state_t                  r_state, w_state_next;
  logic        [CW-1:0]    r_x, w_x_next;
  logic        [CW-1:0]    r_y, w_y_next;
  logic signed [VW-1:0]    r_vy, w_vy_next;
  logic        [15:0]      r_jump, w_jump_next;

  logic signed [CW:0]      w_y_ext;
  logic signed [CW:0]      w_vy_ext;
  logic signed [CW:0]      w_y_sum;
  logic signed [VW:0]      w_vy_dec;
  logic        [CW-1:0]    w_x_plus;
  logic signed [VW-1:0]    w_bounce_vy;

  // Vertical arithmetic is one bit wider than the coordinate so a fall
  // below zero shows up as a negative sum instead of wrapping.
  assign w_y_ext  = {1'b0, r_y};
  assign w_vy_ext = {{(CW+1-VW){r_vy[VW-1]}}, r_vy};
  assign w_y_sum  = w_y_ext + w_vy_ext;
  assign w_vy_dec = {r_vy[VW-1], r_vy} - C_GRAV;
  assign w_x_plus = r_x + C_HSPEED;

`ifdef DOODLE_SPRING_EN
  assign w_bounce_vy = bus.springHit ? C_SPRING : C_JUMP;
`else
  assign w_bounce_vy = C_JUMP;
`endif

  // Next-state and datapath: one physics step when strobed and not dead.
  always_comb begin
    // NOTE: every output of this block gets a hold default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    w_state_next = r_state;
    w_x_next     = r_x;
    w_y_next     = r_y;
    w_vy_next    = r_vy;
    w_jump_next  = r_jump;

    if (bus.physicsUpdate && (r_state != ST_DEAD)) begin
      // Horizontal motion needs exactly one direction; wrap across the edges.
      if (bus.left && !bus.right) begin
        if (r_x < C_HSPEED) w_x_next = r_x - C_HSPEED + C_WIDTH;
        else                w_x_next = r_x - C_HSPEED;
      end else if (bus.right && !bus.left) begin
        if (w_x_plus >= C_WIDTH) w_x_next = w_x_plus - C_WIDTH;
        else                     w_x_next = w_x_plus;
      end

      case (r_state)
        ST_RISE: begin
          // Collisions are ignored on the way up; clamp at the ceiling.
          if (w_y_sum > C_YMAX) w_y_next = C_YMAX[CW-1:0];
          else                  w_y_next = w_y_sum[CW-1:0];
          w_vy_next = w_vy_dec[VW-1:0];
          if (w_vy_dec <= C_VZERO) w_state_next = ST_FALL;
        end
        ST_FALL: begin
          if (bus.hasCollide) begin
            // A bounce wins over bottoming out in the same step.
            w_vy_next    = w_bounce_vy;
            w_jump_next  = r_jump + 16'd1;
            w_state_next = ST_RISE;
          end else if (w_y_sum < C_YZERO) begin
            w_y_next     = '0;
            w_vy_next    = '0;
            w_state_next = ST_DEAD;
          end else begin
            w_y_next = w_y_sum[CW-1:0];
            if (w_vy_dec < C_VMIN) w_vy_next = C_VMIN[VW-1:0];
            else                   w_vy_next = w_vy_dec[VW-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      r_state <= ST_RISE;
      r_x     <= C_XRST;
      r_y     <= '0;
      r_vy    <= C_JUMP;
      r_jump  <= '0;
    end else begin
      r_state <= w_state_next;
      r_x     <= w_x_next;
      r_y     <= w_y_next;
      r_vy    <= w_vy_next;
      r_jump  <= w_jump_next;
    end
  end

  assign bus.doodleX   = r_x;
  assign bus.doodleY   = r_y;
  assign bus.velY      = r_vy;
  assign bus.jumpCount = r_jump;
  assign bus.falling   = (r_state == ST_FALL);
  assign bus.dead      = (r_state == ST_DEAD);

endmodule
